// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register, commit-once register file and retire counter.
// Latency: a captured result drives fwd_* after one edge and is readable from the file after two.
// Backpressure: stall holds the WB entry (it still commits once); flush drops an uncommitted entry.
// Ports: clk/rst (sync, active-high); stall, flush; in_valid, RegwBoolean, Rd, FinalResult from MEM;
//        ra1/ra2 -> rd1/rd2 combinational decode reads; fwd_valid/fwd_rd/fwd_data forwarding source;
//        retire_count = committed valid entries (wraps mod 2**32).
// Optional feature macro: WB_READ_BYPASS_EN (write-through of the committing entry onto rd1/rd2).
module wb_stage #(
  parameter int DW       = 32,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          RegwBoolean,
  input  logic [AW-1:0] Rd,
  input  logic [DW-1:0] FinalResult,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic [31:0]   retire_count
);

  localparam int NREG = 2 ** AW;

  logic          wb_valid;
  logic          wb_regw;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          committed;
  logic [31:0]   retire_cnt;
  logic [DW-1:0] regfile [NREG];

  logic commit;
  logic wr_en;

  // An entry commits in its first resident cycle; flush in that cycle cancels it.
  // rst is handled by priority inside the sequential blocks.
  assign commit = wb_valid & ~committed & ~flush;
  assign wr_en  = commit & wb_regw & ~((ZERO_REG != 0) && (wb_rd == '0));

  // WB pipeline register: rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_regw   <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      committed <= 1'b0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
      committed <= 1'b0;
    end else if (stall) begin
      // Held entry remembers it has already been written/counted.
      if (commit) committed <= 1'b1;
    end else begin
      wb_valid  <= in_valid;
      wb_regw   <= RegwBoolean;
      wb_rd     <= Rd;
      wb_data   <= FinalResult;
      committed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (wr_en) begin
      regfile[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rd1 = regfile[ra1];
    rd2 = regfile[ra2];
`ifdef WB_READ_BYPASS_EN
    // Write-through: the value being committed this cycle is returned immediately.
    if (wr_en && (ra1 == wb_rd)) rd1 = wb_data;
    if (wr_en && (ra2 == wb_rd)) rd2 = wb_data;
`else
    // No write-through: the hazard unit forwards from fwd_* for this cycle.
`endif
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
  end

  assign fwd_valid    = wb_valid & wb_regw;
  assign fwd_rd       = wb_rd;
  assign fwd_data     = wb_data;
  assign retire_count = retire_cnt;

endmodule
